hypot_sched: RTL and testbench
==============================

# hypot_sched

Round-robin scheduler that shares one iterative magnitude engine, floor(sqrt(x²+y²)), between `N_REQ` requesters. It accepts one operand pair at a time and launches the engine. It waits for completion, with a watchdog, and routes the result back to the requester that issued it as a one-hot response pulse. It sits between the requester ports and the single engine instance in the design.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `W`, 8: operand width.
- `TIMEOUT`, 64: maximum WAIT cycles before the request is aborted with an error.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  requester i holds an operand pair.
- `req_x`  in  N_REQ*W  packed x operands; slice i belongs to requester i.
- `req_y`  in  N_REQ*W  packed y operands.
- `req_ready`  out  N_REQ  one-hot accept. Transfer occurs when `req_valid[i] & req_ready[i]`.
- `eng_start`  out  1  one-cycle launch pulse to the engine.
- `eng_x`, `eng_y`  out  W  latched operands, held stable from `eng_start` until the response.
- `eng_done`  in  1  one-cycle completion pulse from the engine.
- `eng_result`  in  W+1  engine result (max 360 for W=8).
- `rsp_valid`  out  N_REQ  one-hot, one-cycle response pulse.
- `rsp_data`  out  W+1  result, valid only with `rsp_valid`.
- `rsp_err`  out  1  timeout flag, qualified by `rsp_valid`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE
    - If no `req_valid` bit is set, stay in IDLE.
    - Otherwise the picker selects the first set bit searching from `ptr` upward, modulo N_REQ.
    - `req_ready[g]` is asserted combinationally in that same cycle.
    - Latch `req_x[g]`, `req_y[g]` and id=g, then go to ISSUE.
  - ISSUE: `eng_start`=1 for exactly one cycle, clear the watchdog counter, go to WAIT.
  - WAIT
    - On `eng_done`: latch `eng_result`, set err=0, go to RESP.
    - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without a done, latch result 0, set err=1, go to RESP.
  - RESP
    - Assert `rsp_valid[id]`=1 with `rsp_data` and `rsp_err` for exactly one cycle.
    - Set `ptr` to (id+1) mod N_REQ, then go to IDLE.
- Round-robin rule: the requester just served becomes lowest priority. After reset, `ptr`=0.
- `req_ready` is 0 in every state except IDLE. At most one bit of `req_ready` is ever set.
- A requester may drop `req_valid` before it is accepted. Nothing is committed until the transfer cycle.
- `eng_done` arriving outside WAIT (stray or late) is ignored.
- `eng_done` and the timeout occurring in the same cycle: done wins, err=0.
- Outside RESP, `rsp_data` and `rsp_err` hold their last values. `rsp_valid` is 0.
- Widths: `eng_result`/`rsp_data` are W+1 bits because sqrt(2·(2^W−1)²) exceeds 2^W−1. No truncation is allowed.

## Timing
- Reset values: `req_ready`=0, `eng_start`=0, `eng_x`=`eng_y`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0. State=IDLE, `ptr`=0, counter=0.
- Reset mid-operation: the request in flight is discarded with no response. The engine shares `rst`.
- With accept in cycle T: `eng_start` is high in cycle T+1, WAIT begins at T+2.
- If `eng_done` is high in cycle T+1+L (L ≥ 1), `rsp_valid` is high in cycle T+2+L.
- Back-to-back throughput: the next accept can occur in the cycle after RESP. Minimum request-to-request spacing is L+3 cycles.
- Timeout: `rsp_valid` with err=1 is high in cycle T+2+TIMEOUT.
- All outputs except `req_ready` are registered. `req_ready` is a combinational function of state, `ptr` and `req_valid`.

## Structure
- Shared package `hypot_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - defaults `HYP_N_REQ`=4, `HYP_W`=8, `HYP_TIMEOUT`=64;
  - a function `hyp_res_w(W)`=W+1.
- One sub-module, `rr_pick`: a combinational round-robin picker with inputs (`req[N_REQ]`, `ptr`) and outputs (one-hot `gnt`, binary `gnt_id`, `any`).
- The FSM, operand latches, watchdog counter and response routing live in `hypot_sched`.

## Test plan
- Single request: `req_valid`=0001, x=3, y=4, engine model with L=10 returning 5.
  - Expected: `req_ready[0]` in the same cycle, `eng_start` one cycle later, `rsp_valid`=0001 with `rsp_data`=5 and `rsp_err`=0 exactly 12 cycles after accept.
- Fairness: all four requesters valid continuously with L=3.
  - Expected: grant order 0,1,2,3,0,1, each requester receives its own result, no double grant.
- Pointer rotation: after serving requester 2, assert requesters 1 and 3 together.
  - Expected: 3 is granted first, then 1.
- Watchdog: the engine never pulses done, TIMEOUT=64.
  - Expected: `rsp_valid[id]` with `rsp_err`=1 and `rsp_data`=0 at T+66. A later done pulse is ignored.
- Reset mid-WAIT: assert `rst` for one cycle.
  - Expected: all outputs 0 asynchronously and no response. With requesters 2 and 0 then valid, requester 0 is granted first.
- Full range: x=y=255, and a stray `eng_done` pulsed during IDLE.
  - Expected: `rsp_data`=360 (9 bits); the stray done produces no response.

Source files
------------

// File: rtl/hypot_pkg.sv
// Shared state encoding, default sizes and result-width helper for the
// magnitude-engine scheduler.
package hypot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } hyp_state_t;

  localparam int HYP_N_REQ   = 4;
  localparam int HYP_W       = 8;
  localparam int HYP_TIMEOUT = 64;

  // sqrt(2*(2^W-1)^2) needs one bit more than the operands.
  function automatic int hyp_res_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first set request at or
// above ptr, wrapping modulo N_REQ.
module rr_pick
  import hypot_pkg::*;
#(
  parameter int N_REQ = HYP_N_REQ,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             any
);

  localparam logic [IDW:0] N_L = (IDW+1)'(N_REQ);

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a,
                                              input logic [IDW-1:0] b);
    logic [IDW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= N_L) s = s - N_L;
    return s[IDW-1:0];
  endfunction

  logic [N_REQ-1:0] rot;
  logic [IDW-1:0]   off;

  // rot[k] is the requester k places after ptr; its lowest set bit wins.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot[gi] = req[wrap_add(ptr, IDW'(gi))];
    end
  endgenerate

  always_comb begin
    off = '0;
    any = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDW'(i);
        any = 1'b1;
      end
    end
  end

  assign gnt_id = wrap_add(ptr, off);

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
      assign gnt[gi] = any && (gnt_id == IDW'(gi));
    end
  endgenerate

endmodule

// File: rtl/hypot_sched.sv
// Round-robin scheduler sharing one iterative magnitude engine between
// N_REQ requesters, with a completion watchdog and one-hot response routing.
module hypot_sched
  import hypot_pkg::*;
#(
  parameter int N_REQ   = HYP_N_REQ,
  parameter int W       = HYP_W,
  parameter int TIMEOUT = HYP_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*W-1:0]      req_x,
  input  logic [N_REQ*W-1:0]      req_y,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    eng_start,
  output logic [W-1:0]            eng_x,
  output logic [W-1:0]            eng_y,
  input  logic                    eng_done,
  input  logic [hyp_res_w(W)-1:0] eng_result,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [hyp_res_w(W)-1:0] rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int RW  = hyp_res_w(W);
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(N_REQ - 1);

  hyp_state_t       state_reg, state_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [IDW-1:0]   id_reg, id_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [W-1:0]     x_reg, x_next;
  logic [W-1:0]     y_reg, y_next;
  logic [RW-1:0]    data_reg, data_next;
  logic             err_reg, err_next;
  logic             start_reg, start_next;
  logic [N_REQ-1:0] rsp_valid_reg, rsp_valid_next;
  logic             busy_reg, busy_next;

  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_id;
  logic             pick_any;
  logic [N_REQ-1:0] id_hot;
  logic [W-1:0]     x_arr [N_REQ];
  logic [W-1:0]     y_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign x_arr[gi]  = req_x[gi*W +: W];
      assign y_arr[gi]  = req_y[gi*W +: W];
      assign id_hot[gi] = (id_reg == IDW'(gi));
    end
  endgenerate

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req    (req_valid),
    .ptr    (ptr_reg),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (pick_any)
  );

  // Accept is offered only in IDLE, so transfer and latching share one cycle.
  assign req_ready = (state_reg == IDLE && !rst) ? gnt : '0;

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    id_next        = id_reg;
    cnt_next       = cnt_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    data_next      = data_reg;
    err_next       = err_reg;
    start_next     = 1'b0;
    rsp_valid_next = '0;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          id_next    = gnt_id;
          x_next     = x_arr[gnt_id];
          y_next     = y_arr[gnt_id];
          start_next = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // A done on the final watchdog cycle still counts as success.
        if (eng_done) begin
          data_next      = eng_result;
          err_next       = 1'b0;
          rsp_valid_next = id_hot;
          state_next     = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          data_next      = '0;
          err_next       = 1'b1;
          rsp_valid_next = id_hot;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        ptr_next   = (id_reg == ID_LAST) ? '0 : id_reg + 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      id_reg        <= '0;
      cnt_reg       <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      data_reg      <= '0;
      err_reg       <= 1'b0;
      start_reg     <= 1'b0;
      rsp_valid_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      id_reg        <= id_next;
      cnt_reg       <= cnt_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      data_reg      <= data_next;
      err_reg       <= err_next;
      start_reg     <= start_next;
      rsp_valid_reg <= rsp_valid_next;
      busy_reg      <= busy_next;
    end
  end

  assign eng_start = start_reg;
  assign eng_x     = x_reg;
  assign eng_y     = y_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = data_reg;
  assign rsp_err   = err_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_hypot_sched.sv
// Self-checking bench for hypot_sched: transaction-level reference model,
// engine model with programmable latency, directed cases plus random traffic.
module tb_hypot_sched;
  import hypot_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 64;
  localparam int RW = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*W-1:0]  req_x, req_y;
  logic            eng_start, eng_done, rsp_err, busy;
  logic [W-1:0]    eng_x, eng_y;
  logic [RW-1:0]   eng_result, rsp_data;

  always #5 clk = ~clk;

  hypot_sched #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int first_bit(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Transaction-level reference: one outstanding job, known accept/response cycles.
  bit  m_active = 0;
  int  m_ptr = 0, m_T, m_R, m_id, m_x, m_y, m_data, m_err;
  int  last_data = 0, last_err = 0;
  int  lat_force = -1;
  int  cur_lat = 1;

  typedef struct { int c; int id; int data; int err; } rsp_t;
  int   g_log[$];
  int   g_cyc[$];
  rsp_t r_log[$];

  int c, p, lat, rsel;
  bit idle;
  logic [N-1:0] hs, exp_rdy, exp_rv;
  rsp_t rr;

  always @(negedge clk) begin
    if (rst) begin
      m_active  = 0;
      m_ptr     = 0;
      last_data = 0;
      last_err  = 0;
    end else begin
      c  = cyc;
      hs = req_valid & req_ready;
      if (hs != '0) begin
        g_log.push_back(first_bit(hs));
        g_cyc.push_back(c);
      end
      if (rsp_valid != '0) begin
        rr.c = c; rr.id = first_bit(rsp_valid); rr.data = int'(rsp_data); rr.err = int'(rsp_err);
        r_log.push_back(rr);
      end
      idle    = !m_active;
      p       = pick(req_valid, m_ptr);
      exp_rdy = '0;
      if (idle && p >= 0) exp_rdy[p] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("busy", 64'(busy), 64'(m_active && c > m_T));
      chk("eng_start", 64'(eng_start), 64'(m_active && c == m_T + 1));
      if (m_active && c > m_T) begin
        chk("eng_x", 64'(eng_x), 64'(m_x));
        chk("eng_y", 64'(eng_y), 64'(m_y));
      end
      if (m_active && c == m_R) begin
        exp_rv = '0;
        exp_rv[m_id] = 1'b1;
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        chk("rsp_data", 64'(rsp_data), 64'(m_data));
        chk("rsp_err", 64'(rsp_err), 64'(m_err));
        last_data = m_data;
        last_err  = m_err;
        m_ptr     = (m_id + 1) % N;
        m_active  = 0;
      end else begin
        chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
        chk("rsp_data_hold", 64'(rsp_data), 64'(last_data));
        chk("rsp_err_hold", 64'(rsp_err), 64'(last_err));
      end
      if (idle && p >= 0) begin
        m_id = p;
        m_T  = c;
        m_x  = int'(req_x[p*W +: W]);
        m_y  = int'(req_y[p*W +: W]);
        rsel = $urandom_range(0, 31);
        if (lat_force >= 0) lat = lat_force;
        else if (rsel == 0) lat = 0;
        else if (rsel == 1) lat = TO;
        else if (rsel == 2) lat = TO + 1;
        else lat = $urandom_range(1, 6);
        cur_lat = lat;
        if (lat >= 1 && lat <= TO) begin
          m_R = c + 2 + lat; m_data = isqrt(m_x * m_x + m_y * m_y); m_err = 0;
        end else begin
          m_R = c + 2 + TO; m_data = 0; m_err = 1;
        end
        m_active = 1;
      end
    end
  end

  // Engine model: done cur_lat cycles after start (0 = never), plus stray pulses.
  int            done_at = -1;
  logic [RW-1:0] eng_res_q = '0;
  bit            stray_now = 0;
  bit            stray_en = 0;

  always @(negedge clk) begin
    if (rst) done_at = -1;
    else if (eng_start) begin
      done_at   = (cur_lat > 0) ? cyc + cur_lat : -1;
      eng_res_q = RW'(isqrt(int'(eng_x) * int'(eng_x) + int'(eng_y) * int'(eng_y)));
    end
  end

  initial begin
    eng_done   = 1'b0;
    eng_result = '0;
    forever begin
      @(posedge clk); #1;
      if (cyc == done_at) begin
        eng_done   = 1'b1;
        eng_result = eng_res_q;
      end else begin
        eng_done   = stray_now || (stray_en && !m_active && ($urandom_range(0, 3) == 0));
        eng_result = RW'($urandom_range(0, 511));
        stray_now  = 0;
      end
    end
  end

  task automatic set_op(input int i, input int x, input int y);
    req_x[i*W +: W] = W'(x);
    req_y[i*W +: W] = W'(y);
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int k = 0;
    while (g_log.size() < n && k < budget) begin @(posedge clk); #1; k++; end
    chk("grant_wait", 64'(g_log.size() >= n), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (m_active && k < budget) begin @(posedge clk); #1; k++; end
    chk("idle_wait", 64'(!m_active), 64'd1);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic int g_at(input int i);
    return (i < g_log.size()) ? g_log[i] : -1;
  endfunction

  function automatic int gc_at(input int i);
    return (i < g_cyc.size()) ? g_cyc[i] : -1;
  endfunction

  function automatic rsp_t r_at(input int i);
    rsp_t d;
    d.c = -1; d.id = -1; d.data = -1; d.err = -1;
    return (i < r_log.size()) ? r_log[i] : d;
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_eng_start"}, 64'(eng_start), 64'd0);
    chk({tag, "_eng_x"}, 64'(eng_x), 64'd0);
    chk({tag, "_eng_y"}, 64'(eng_y), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  int   n0, r0;
  rsp_t q;
  int   fair_res [4] = '{5, 13, 17, 25};

  initial begin
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0;
    #2;
    check_outputs_zero("reset");
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;

    // Single request, L=10: response 12 cycles after accept.
    lat_force = 10; set_op(0, 3, 4);
    n0 = g_log.size(); r0 = r_log.size();
    req_valid = 4'b0001;
    wait_grants(n0 + 1, 20); req_valid = '0;
    wait_idle(100);
    q = r_at(r0);
    chk("single_gnt", 64'(g_at(n0)), 64'd0);
    chk("single_id", 64'(q.id), 64'd0);
    chk("single_data", 64'(q.data), 64'd5);
    chk("single_err", 64'(q.err), 64'd0);
    chk("single_lat", 64'(q.c - gc_at(n0)), 64'd12);

    // Fairness from reset with all four requesters valid.
    pulse_rst();
    lat_force = 3;
    set_op(0, 3, 4); set_op(1, 5, 12); set_op(2, 8, 15); set_op(3, 7, 24);
    n0 = g_log.size(); r0 = r_log.size();
    req_valid = 4'b1111;
    wait_grants(n0 + 6, 100); req_valid = '0;
    wait_idle(100);
    for (int k = 0; k < 6; k++) begin
      chk("fair_order", 64'(g_at(n0 + k)), 64'(k % 4));
      q = r_at(r0 + k);
      chk("fair_rsp_id", 64'(q.id), 64'(k % 4));
      chk("fair_rsp_data", 64'(q.data), 64'(fair_res[k % 4]));
    end

    // Pointer rotation: serve 2, then 1 and 3 together -> 3 first.
    lat_force = 2;
    req_valid = 4'b0100;
    n0 = g_log.size();
    wait_grants(n0 + 1, 20); req_valid = '0;
    wait_idle(50);
    n0 = g_log.size();
    req_valid = 4'b1010;
    wait_grants(n0 + 1, 20);
    if (g_at(n0) >= 0) req_valid[g_at(n0)] = 1'b0;
    wait_grants(n0 + 2, 30); req_valid = '0;
    wait_idle(50);
    chk("rot_first", 64'(g_at(n0)), 64'd3);
    chk("rot_second", 64'(g_at(n0 + 1)), 64'd1);

    // Watchdog: engine never answers.
    lat_force = 0; set_op(1, 9, 9);
    n0 = g_log.size(); r0 = r_log.size();
    req_valid = 4'b0010;
    wait_grants(n0 + 1, 20); req_valid = '0;
    wait_idle(120);
    q = r_at(r0);
    chk("wd_id", 64'(q.id), 64'd1);
    chk("wd_err", 64'(q.err), 64'd1);
    chk("wd_data", 64'(q.data), 64'd0);
    chk("wd_lat", 64'(q.c - gc_at(n0)), 64'(TO + 2));
    stray_now = 1;
    step(5);
    chk("wd_late_done", 64'(r_log.size()), 64'(r0 + 1));

    // Reset mid-WAIT discards the job; pointer returns to 0.
    lat_force = 20; set_op(0, 6, 8);
    n0 = g_log.size();
    req_valid = 4'b0001;
    wait_grants(n0 + 1, 20); req_valid = '0;
    step(4);
    r0 = r_log.size();
    #2 rst = 1'b1;
    #1 check_outputs_zero("midrst");
    @(posedge clk); #3 rst = 1'b0;
    step(30);
    chk("midrst_no_rsp", 64'(r_log.size()), 64'(r0));
    lat_force = 2; set_op(0, 0, 0); set_op(2, 1, 1);
    n0 = g_log.size();
    req_valid = 4'b0101;
    wait_grants(n0 + 1, 20);
    if (g_at(n0) >= 0) req_valid[g_at(n0)] = 1'b0;
    wait_grants(n0 + 2, 30); req_valid = '0;
    wait_idle(50);
    chk("postrst_first", 64'(g_at(n0)), 64'd0);
    chk("postrst_second", 64'(g_at(n0 + 1)), 64'd2);

    // Full range plus stray done while idle.
    r0 = r_log.size();
    stray_now = 1;
    step(4);
    chk("stray_no_rsp", 64'(r_log.size()), 64'(r0));
    lat_force = 5; set_op(0, 255, 255);
    n0 = g_log.size();
    req_valid = 4'b0001;
    wait_grants(n0 + 1, 20); req_valid = '0;
    wait_idle(50);
    q = r_at(r0);
    chk("full_data", 64'(q.data), 64'd360);
    chk("full_err", 64'(q.err), 64'd0);

    // Random traffic with dropping valids, varied latency and stray dones.
    lat_force = -1; stray_en = 1;
    for (int t = 0; t < 3000; t++) begin
      req_valid = N'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) req_valid = '0;
      for (int i = 0; i < N; i++) set_op(i, $urandom_range(0, 255), $urandom_range(0, 255));
      step(1);
    end
    req_valid = '0; stray_en = 0;
    wait_idle(200);
    chk("random_served", 64'(g_log.size() > 100), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
